// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter driving one 8N1 UART transmitter (LSB first).
// Bit time is DIV = CLOCK(MHz)*1e6/BAUD clock cycles; a frame lasts 10*DIV cycles.
module uart_tx_arbiter #(
  parameter int CLOCK = 50,
  parameter int BAUD  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  localparam int DIV   = (CLOCK * 1_000_000) / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_arbiter: baud divider DIV must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;

  logic [1:0]       arb_s;
  logic             win_any_s;
  logic             win_id_s;
  logic             idle_s;
  logic             bit_end_s;

  // Returns {someone_wins, winner_id}; on contention the requester not served last wins.
  function automatic logic [1:0] arbitrate(input logic v0, input logic v1, input logic last);
    logic [1:0] res;
    res = 2'b00;
    if (v0 && v1) begin
      res = {1'b1, ~last};
    end else if (v1) begin
      res = 2'b11;
    end else if (v0) begin
      res = 2'b10;
    end else begin
      res = 2'b00;
    end
    return res;
  endfunction

  assign arb_s     = arbitrate(req0_valid, req1_valid, last_q);
  assign win_any_s = arb_s[1];
  assign win_id_s  = arb_s[0];
  assign idle_s    = (state_q == S_IDLE) && !rst;
  assign bit_end_s = (cnt_q == CNT_W'(DIV - 1));

  assign req0_ready = idle_s && win_any_s && !win_id_s;
  assign req1_ready = idle_s && win_any_s && win_id_s;

  // Next-state logic; tx is precomputed from the next state so the pin comes straight off a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    grant_d = grant_q;
    last_d  = last_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
        if (win_any_s) begin
          state_d = S_START;
          shift_d = win_id_s ? req1_data : req0_data;
          grant_d = win_id_s;
          last_d  = win_id_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces the line idle-high at once and favours req0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
